// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, stall hold and flush bubbles.
// Define PIPE_PERF_EN to add saturating bubble/flush event counters.
module id_ex_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_func3,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_func3,
`ifdef PIPE_PERF_EN
  output logic [31:0]       perf_bubbles,
  output logic [31:0]       perf_flushes,
`endif
  output logic              load_use_stall
);

  localparam int MEMRW_BIT  = 5;
  localparam int REGWEN_BIT = 4;
  localparam int WBSEL_LO   = 2;

  logic ex_is_load;
  logic rd_match;
  logic bubble_load_use;

  // A load writes back from memory (WBSel=0) into a real register without storing.
  assign ex_is_load = ex_valid & ex_ctrl[REGWEN_BIT] & ~ex_ctrl[MEMRW_BIT] &
                      (ex_ctrl[WBSEL_LO+1:WBSEL_LO] == 2'b00) & (ex_rd != 5'd0);
  assign rd_match   = (ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2));

  assign load_use_stall  = ex_is_load & id_valid & rd_match;
  assign bubble_load_use = ~flush & ~ex_stall & load_use_stall;

  always_ff @(posedge clk) begin
    if (rst || flush || (!ex_stall && load_use_stall)) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_func3    <= '0;
    end else if (!ex_stall) begin
      ex_valid    <= id_valid;
      ex_ctrl     <= id_valid ? id_ctrl : '0;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_func3    <= id_func3;
    end
  end

`ifdef PIPE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles <= '0;
      perf_flushes <= '0;
    end else begin
      if (bubble_load_use && perf_bubbles != 32'hFFFF_FFFF)
        perf_bubbles <= perf_bubbles + 32'd1;
      if (flush && id_valid && perf_flushes != 32'hFFFF_FFFF)
        perf_flushes <= perf_flushes + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = bubble_load_use;
`endif

endmodule
